axi_slave_mem: RTL
==================

# axi_slave_mem

Single-beat AXI memory responder (slave) paired with the core's AXI master port: accepts independent write-address/write-data transfers, commits them to an internal word-addressed RAM under byte strobes, and returns a write response; accepts read addresses and returns one data beat per request. It sits on the far side of the instruction/data bus as the simulation/FPGA main memory model. Bursts are not supported: AWLEN/ARLEN are accepted but ignored, and every transfer is one beat.

## Interface
- ADDR_WIDTH, 64, address bus width
- DATA_WIDTH, 64, data bus width (multiple of 8)
- ADDR_SEL, 8, strobe width = DATA_WIDTH/8
- MEM_DEPTH, 1024, RAM depth in words (power of 2); IDX_W = log2(MEM_DEPTH), OFF_W = log2(ADDR_SEL)

- aclk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- AWADDR  in  ADDR_WIDTH  write address
- AWLEN  in  1  ignored
- AWVALID  in  1  write address valid
- AWREADY  out  1  write address ready
- WDATA  in  DATA_WIDTH  write data
- WSTRB  in  ADDR_SEL  byte enables, bit i -> WDATA[8i+7:8i]
- WLAST  in  1  ignored
- WVALID  in  1  write data valid
- WREADY  out  1  write data ready
- BVALID  out  1  write response valid
- BREADY  in  1  write response ready
- ARADDR  in  ADDR_WIDTH  read address
- ARLEN  in  1  ignored
- ARVALID  in  1  read address valid
- ARREADY  out  1  read address ready
- RDATA  out  DATA_WIDTH  read data
- RLAST  out  1  last beat, equals RVALID
- RVALID  out  1  read data valid
- RREADY  in  1  read data ready

## Operation
- All outputs registered. Reset values: AWREADY=0, WREADY=0, BVALID=0, ARREADY=0, RVALID=0, RLAST=0, RDATA=0. RAM contents not cleared by reset.
- Word index = ADDR[OFF_W +: IDX_W]; upper bits and low OFF_W bits ignored (addresses alias modulo MEM_DEPTH words).
- Write channel FSM, states W_IDLE, W_RESP; flags aw_got, w_got, latched awaddr/wdata/wstrb.
  - W_IDLE: AWREADY = !aw_got, WREADY = !w_got. AW handshake latches address, sets aw_got; W handshake latches data+strobe, sets w_got. Either order or same cycle.
  - When both captured (including captured on this edge): RAM bytes with strobe=1 updated at that edge, flags cleared, AWREADY=WREADY=0, BVALID=1, go W_RESP.
  - W_RESP: hold BVALID until BVALID&&BREADY; then BVALID=0, AWREADY=WREADY=1, W_IDLE.
  - WSTRB=0 commits nothing but still produces a response.
- Read channel FSM, states R_IDLE, R_DATA.
  - R_IDLE: ARREADY=1. On ARVALID&&ARREADY: RDATA <= RAM[index] (value before any write committing on the same edge), RVALID=RLAST=1, ARREADY=0, go R_DATA.
  - R_DATA: RDATA/RVALID/RLAST held stable until RVALID&&RREADY; then RVALID=RLAST=0, ARREADY=1, R_IDLE. RDATA retains last value.
- Read and write channels fully independent; may be active concurrently.

## Timing
- First cycle after rst deasserts: readies still 0; they rise at the following edge (AWREADY=WREADY=ARREADY=1 from cycle 2).
- Read latency: AR handshake at edge N -> RVALID high in cycle after N; minimum read issue interval 2 cycles (ARREADY low while RVALID high).
- Write: last of AW/W handshakes at edge N -> RAM updated at N, BVALID high after N; next AW/W accepted the edge after B handshake.
- Read-after-write: a read whose AR handshake is at or after the edge following a write commit returns new data; AR on the commit edge itself returns old data.
- Input VALIDs may drop without handshake (master-side violation); slave latches nothing without VALID&&READY.
- rst asserted mid-transfer: at that edge all FSMs -> idle, flags cleared, outputs to reset values; partial (uncommitted) write discarded; committed RAM writes kept.

## Test plan
- Write addr 0x10 data 0x1122334455667788 WSTRB=0xFF, AW/W same cycle, BREADY=1 -> BVALID one cycle after handshake; read 0x10 -> RDATA=0x1122334455667788, RLAST=1.
- Partial strobe: word 0x20 preset to 0xFFFFFFFFFFFFFFFF, write 0x0 with WSTRB=0x0F -> read returns 0xFFFFFFFF00000000.
- AW at cycle 5, W at cycle 9 -> AWREADY low cycles 6-9, no RAM change until edge 9, BVALID from cycle 10; write to 0x2010 with MEM_DEPTH=1024 aliases to 0x10.
- Back-pressure: BREADY low 4 cycles and RREADY low 3 cycles -> BVALID/RVALID/RDATA stable; AWREADY/WREADY/ARREADY stay 0 until respective handshake.
- Same-edge AR and write commit to 0x30 (old 0xA, new 0xB) -> RDATA=0xA; next read -> 0xB.
- rst pulse after AW accepted but before W -> AWREADY/WREADY low next cycle, BVALID never asserts, RAM at that address unchanged.

Source files
------------

// File: rtl/axi_slave_mem_if.sv
// rtl/axi_slave_mem_if.sv - AXI single-beat memory bus signals with master/slave views
interface axi_slave_mem_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_SEL   = 8
);
    logic [ADDR_WIDTH-1:0] AWADDR;
    logic                  AWLEN;
    logic                  AWVALID;
    logic                  AWREADY;
    logic [DATA_WIDTH-1:0] WDATA;
    logic [ADDR_SEL-1:0]   WSTRB;
    logic                  WLAST;
    logic                  WVALID;
    logic                  WREADY;
    logic                  BVALID;
    logic                  BREADY;
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic                  ARLEN;
    logic                  ARVALID;
    logic                  ARREADY;
    logic [DATA_WIDTH-1:0] RDATA;
    logic                  RLAST;
    logic                  RVALID;
    logic                  RREADY;

    modport slave (
        input  AWADDR, AWLEN, AWVALID, WDATA, WSTRB, WLAST, WVALID, BREADY,
        input  ARADDR, ARLEN, ARVALID, RREADY,
        output AWREADY, WREADY, BVALID, ARREADY, RDATA, RLAST, RVALID
    );

    modport master (
        output AWADDR, AWLEN, AWVALID, WDATA, WSTRB, WLAST, WVALID, BREADY,
        output ARADDR, ARLEN, ARVALID, RREADY,
        input  AWREADY, WREADY, BVALID, ARREADY, RDATA, RLAST, RVALID
    );
endinterface

// File: rtl/axi_slave_mem.sv
// rtl/axi_slave_mem.sv - single-beat AXI memory responder with byte-strobed word RAM
module axi_slave_mem #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_SEL   = 8,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic              aclk,
    input  logic              rst,
    axi_slave_mem_if.slave    bus
);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int OFF_W = $clog2(ADDR_SEL);

    typedef enum logic {W_IDLE, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    wstate_t               r_wstate, w_wstate_n;
    logic                  r_aw_got, w_aw_got_n;
    logic                  r_w_got, w_w_got_n;
    logic [IDX_W-1:0]      r_awidx, w_awidx_n;
    logic [DATA_WIDTH-1:0] r_wdata, w_wdata_n;
    logic [ADDR_SEL-1:0]   r_wstrb, w_wstrb_n;
    logic                  r_awready, w_awready_n;
    logic                  r_wready, w_wready_n;
    logic                  r_bvalid, w_bvalid_n;
    logic                  w_we;
    logic [IDX_W-1:0]      w_we_idx;
    logic [DATA_WIDTH-1:0] w_we_data;
    logic [ADDR_SEL-1:0]   w_we_strb;

    rstate_t               r_rstate, w_rstate_n;
    logic                  r_arready, w_arready_n;
    logic                  r_rvalid, w_rvalid_n;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  w_rd_load;

    wire w_aw_hs = bus.AWVALID && r_awready;
    wire w_w_hs  = bus.WVALID && r_wready;
    wire w_ar_hs = bus.ARVALID && r_arready;
    wire w_unused = &{1'b0, bus.AWLEN, bus.WLAST, bus.ARLEN, bus.AWADDR, bus.ARADDR};

    always_comb begin
        w_wstate_n  = r_wstate;
        w_aw_got_n  = r_aw_got;
        w_w_got_n   = r_w_got;
        w_awidx_n   = r_awidx;
        w_wdata_n   = r_wdata;
        w_wstrb_n   = r_wstrb;
        w_awready_n = r_awready;
        w_wready_n  = r_wready;
        w_bvalid_n  = r_bvalid;
        w_we        = 1'b0;
        w_we_idx    = r_awidx;
        w_we_data   = r_wdata;
        w_we_strb   = r_wstrb;
        case (r_wstate)
            W_IDLE: begin
                if (w_aw_hs) begin
                    w_aw_got_n = 1'b1;
                    w_awidx_n  = bus.AWADDR[OFF_W +: IDX_W];
                end
                if (w_w_hs) begin
                    w_w_got_n = 1'b1;
                    w_wdata_n = bus.WDATA;
                    w_wstrb_n = bus.WSTRB;
                end
                // Commit on the edge where the second half arrives, bypassing the latches.
                if (w_aw_got_n && w_w_got_n) begin
                    w_we        = !rst;
                    w_we_idx    = w_awidx_n;
                    w_we_data   = w_wdata_n;
                    w_we_strb   = w_wstrb_n;
                    w_aw_got_n  = 1'b0;
                    w_w_got_n   = 1'b0;
                    w_awready_n = 1'b0;
                    w_wready_n  = 1'b0;
                    w_bvalid_n  = 1'b1;
                    w_wstate_n  = W_RESP;
                end else begin
                    w_awready_n = !w_aw_got_n;
                    w_wready_n  = !w_w_got_n;
                end
            end
            W_RESP: begin
                if (bus.BREADY) begin
                    w_bvalid_n  = 1'b0;
                    w_awready_n = 1'b1;
                    w_wready_n  = 1'b1;
                    w_wstate_n  = W_IDLE;
                end
            end
            default: w_wstate_n = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            r_wstate  <= W_IDLE;
            r_aw_got  <= 1'b0;
            r_w_got   <= 1'b0;
            r_awidx   <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
        end else begin
            r_wstate  <= w_wstate_n;
            r_aw_got  <= w_aw_got_n;
            r_w_got   <= w_w_got_n;
            r_awidx   <= w_awidx_n;
            r_wdata   <= w_wdata_n;
            r_wstrb   <= w_wstrb_n;
            r_awready <= w_awready_n;
            r_wready  <= w_wready_n;
            r_bvalid  <= w_bvalid_n;
        end
    end

    always_ff @(posedge aclk) begin
        if (w_we) begin
            for (int i = 0; i < ADDR_SEL; i++) begin
                if (w_we_strb[i]) r_mem[w_we_idx][8*i +: 8] <= w_we_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        w_rstate_n  = r_rstate;
        w_arready_n = r_arready;
        w_rvalid_n  = r_rvalid;
        w_rd_load   = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                w_arready_n = 1'b1;
                if (w_ar_hs) begin
                    w_rd_load   = 1'b1;
                    w_rvalid_n  = 1'b1;
                    w_arready_n = 1'b0;
                    w_rstate_n  = R_DATA;
                end
            end
            R_DATA: begin
                if (bus.RREADY) begin
                    w_rvalid_n  = 1'b0;
                    w_arready_n = 1'b1;
                    w_rstate_n  = R_IDLE;
                end
            end
            default: w_rstate_n = R_IDLE;
        endcase
    end

    // RAM read sees the pre-edge contents, so a same-edge write commit returns old data.
    always_ff @(posedge aclk) begin
        if (rst) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_rstate  <= w_rstate_n;
            r_arready <= w_arready_n;
            r_rvalid  <= w_rvalid_n;
            if (w_rd_load) r_rdata <= r_mem[bus.ARADDR[OFF_W +: IDX_W]];
        end
    end

    assign bus.AWREADY = r_awready;
    assign bus.WREADY  = r_wready;
    assign bus.BVALID  = r_bvalid;
    assign bus.ARREADY = r_arready;
    assign bus.RVALID  = r_rvalid;
    assign bus.RLAST   = r_rvalid;
    assign bus.RDATA   = r_rdata;
endmodule
